// File: rtl/l2_cache_read_multi.sv
// l2_cache_read_multi: L2 data-read stage between directory and response stages.
// Latency: READ_LATENCY cycles (1..3) from request to SRAM data and delayed sidebands.
// Backpressure: none, so one request can be accepted every cycle and the pipeline never stalls.
//
// Ports: clk/reset (async, active-low); in_* request from the directory stage;
// wr_* SRAM write port with write-first bypass; out_* sidebands delayed by READ_LATENCY,
// plus out_line_is_dirty, out_store_sync_success and out_cache_data.
// The optional reservation timeout is enabled by defining L2_SYNC_TIMEOUT_EN.
module l2_cache_read_multi #(
  parameter int NUM_WAYS         = 4,
  parameter int NUM_SETS         = 256,
  parameter int LINE_BITS        = 512,
  parameter int ADDR_WIDTH       = 26,
  parameter int NUM_CORES        = 1,
  parameter int STRANDS_PER_CORE = 4,
  parameter int READ_LATENCY     = 1,
  parameter int SYNC_TIMEOUT     = 1023
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               in_valid,
  input  logic [2:0]                                         in_op,
  input  logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] in_core,
  input  logic [$clog2(STRANDS_PER_CORE)-1:0]                in_strand,
  input  logic [ADDR_WIDTH-1:0]                              in_address,
  input  logic                                               in_is_fill,
  input  logic                                               in_cache_hit,
  input  logic [$clog2(NUM_WAYS)-1:0]                        in_hit_way,
  input  logic [$clog2(NUM_WAYS)-1:0]                        in_fill_way,
  input  logic [ADDR_WIDTH-$clog2(NUM_SETS)-1:0]             in_old_tag,
  input  logic [NUM_WAYS-1:0]                                in_dirty,
  input  logic                                               wr_enable,
  input  logic [$clog2(NUM_WAYS*NUM_SETS)-1:0]               wr_index,
  input  logic [LINE_BITS-1:0]                               wr_data,
  output logic                                               out_valid,
  output logic [2:0]                                         out_op,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] out_core,
  output logic [$clog2(STRANDS_PER_CORE)-1:0]                out_strand,
  output logic [ADDR_WIDTH-1:0]                              out_address,
  output logic                                               out_is_fill,
  output logic                                               out_cache_hit,
  output logic [$clog2(NUM_WAYS)-1:0]                        out_hit_way,
  output logic [$clog2(NUM_WAYS)-1:0]                        out_fill_way,
  output logic [ADDR_WIDTH-$clog2(NUM_SETS)-1:0]             out_old_tag,
  output logic                                               out_line_is_dirty,
  output logic                                               out_store_sync_success,
  output logic [LINE_BITS-1:0]                               out_cache_data
);
  localparam int WAYW  = $clog2(NUM_WAYS);
  localparam int SETW  = $clog2(NUM_SETS);
  localparam int TAGW  = ADDR_WIDTH - SETW;
  localparam int CORW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int STRW  = $clog2(STRANDS_PER_CORE);
  localparam int TOTAL = NUM_CORES * STRANDS_PER_CORE;
  localparam int IDXW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int LAT   = READ_LATENCY;

  localparam logic [2:0] OP_STORE      = 3'd1;
  localparam logic [2:0] OP_FLUSH      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
  localparam logic [2:0] OP_STORE_SYNC = 3'd5;

  if (READ_LATENCY < 1 || READ_LATENCY > 3 || SYNC_TIMEOUT < 1 || NUM_WAYS < 2) begin : g_bad_params
    $error("l2_cache_read_multi: illegal parameter value");
  end

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [CORW-1:0]  core;
    logic [STRW-1:0]  strand;
    logic [ADDR_WIDTH-1:0] addr;
    logic             is_fill;
    logic             hit;
    logic [WAYW-1:0]  hit_way;
    logic [WAYW-1:0]  fill_way;
    logic [TAGW-1:0]  old_tag;
    logic             dirty;
    logic             sync_ok;
  } sb_t;

  logic [LINE_BITS-1:0]  r_mem [NUM_WAYS*NUM_SETS];
  logic [LINE_BITS-1:0]  r_data [LAT];
  sb_t                   r_sb [LAT];
  logic [ADDR_WIDTH-1:0] r_res_addr [TOTAL];
  logic [TOTAL-1:0]      r_res_valid;
`ifdef L2_SYNC_TIMEOUT_EN
  localparam int CNTW = $clog2(SYNC_TIMEOUT + 1);
  logic [CNTW-1:0]       r_cnt [TOTAL];
`endif

  logic                  w_rd_en;
  logic [WAYW+SETW-1:0]  w_rd_idx;
  logic [LINE_BITS-1:0]  w_rd_data;
  logic [IDXW-1:0]       w_req_idx;
  logic                  w_can_sync;
  logic                  w_clr_req;
  logic [ADDR_WIDTH-1:0] w_evict_addr;
  logic [TOTAL-1:0]      w_set;
  logic [TOTAL-1:0]      w_clr;
  sb_t                   w_sb;

  assign w_rd_en      = in_valid & (in_cache_hit | in_is_fill);
  assign w_rd_idx     = {(in_is_fill ? in_fill_way : in_hit_way), in_address[SETW-1:0]};
  // Write-first: a same-cycle write to the index being read is forwarded.
  assign w_rd_data    = (wr_enable && (wr_index == w_rd_idx)) ? wr_data : r_mem[w_rd_idx];
  assign w_evict_addr = {in_old_tag, in_address[SETW-1:0]};

  always_comb begin
    w_req_idx = '0;
    // A single core has no core bits in the index, whatever in_core carries.
    if (NUM_CORES == 1) w_req_idx = IDXW'(in_strand);
    else                w_req_idx = IDXW'(in_core) * IDXW'(STRANDS_PER_CORE) + IDXW'(in_strand);
  end

  assign w_can_sync = (in_op == OP_STORE_SYNC) && r_res_valid[w_req_idx] &&
                      (r_res_addr[w_req_idx] == in_address);
  assign w_clr_req  = (in_op == OP_STORE) || (in_op == OP_FLUSH) || (in_op == OP_INVALIDATE) ||
                      ((in_op == OP_STORE_SYNC) && w_can_sync);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < TOTAL; i++) begin
      if (w_rd_en) begin
        w_set[i] = (in_op == OP_LOAD_SYNC) && (w_req_idx == IDXW'(i));
        w_clr[i] = (w_clr_req && (r_res_addr[i] == in_address)) ||
                   (in_is_fill && (r_res_addr[i] == w_evict_addr));
      end
    end
  end

  always_comb begin
    w_sb          = '0;
    w_sb.valid    = in_valid;
    w_sb.op       = in_op;
    w_sb.core     = in_core;
    w_sb.strand   = in_strand;
    w_sb.addr     = in_address;
    w_sb.is_fill  = in_is_fill;
    w_sb.hit      = in_cache_hit;
    w_sb.hit_way  = in_hit_way;
    w_sb.fill_way = in_fill_way;
    w_sb.old_tag  = in_old_tag;
    w_sb.dirty    = in_dirty[(in_op == OP_FLUSH) ? in_hit_way : in_fill_way];
    w_sb.sync_ok  = w_rd_en & w_can_sync;
  end

  always_ff @(posedge clk) begin
    if (wr_enable) r_mem[wr_index] <= wr_data;
  end

  // Data stages only advance behind a real read so out_cache_data holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LAT; k++) begin
        r_data[k] <= '0;
        r_sb[k]   <= '0;
      end
    end else begin
      r_sb[0] <= w_sb;
      if (w_rd_en) r_data[0] <= w_rd_data;
      for (int k = 1; k < LAT; k++) begin
        r_sb[k] <= r_sb[k-1];
        if (r_sb[k-1].valid && (r_sb[k-1].hit || r_sb[k-1].is_fill)) r_data[k] <= r_data[k-1];
      end
    end
  end

  // Set beats clear on the requester's own entry; expiry only acts when neither happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= '0;
      for (int i = 0; i < TOTAL; i++) begin
        r_res_addr[i] <= '0;
`ifdef L2_SYNC_TIMEOUT_EN
        r_cnt[i]      <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        if (w_set[i]) begin
          r_res_valid[i] <= 1'b1;
          r_res_addr[i]  <= in_address;
`ifdef L2_SYNC_TIMEOUT_EN
          r_cnt[i]       <= CNTW'(SYNC_TIMEOUT);
`endif
        end else if (w_clr[i]) begin
          r_res_valid[i] <= 1'b0;
        end
`ifdef L2_SYNC_TIMEOUT_EN
        else if (r_res_valid[i]) begin
          if (r_cnt[i] == '0) r_res_valid[i] <= 1'b0;
          else                r_cnt[i]       <= r_cnt[i] - CNTW'(1);
        end
`endif
      end
    end
  end

  assign out_valid              = r_sb[LAT-1].valid;
  assign out_op                 = r_sb[LAT-1].op;
  assign out_core               = r_sb[LAT-1].core;
  assign out_strand             = r_sb[LAT-1].strand;
  assign out_address            = r_sb[LAT-1].addr;
  assign out_is_fill            = r_sb[LAT-1].is_fill;
  assign out_cache_hit          = r_sb[LAT-1].hit;
  assign out_hit_way            = r_sb[LAT-1].hit_way;
  assign out_fill_way           = r_sb[LAT-1].fill_way;
  assign out_old_tag            = r_sb[LAT-1].old_tag;
  assign out_line_is_dirty      = r_sb[LAT-1].dirty;
  assign out_store_sync_success = r_sb[LAT-1].sync_ok;
  assign out_cache_data         = r_data[LAT-1];

  a_fill_not_hit: assert property (@(posedge clk) disable iff (!reset)
    !(in_valid && in_is_fill && in_cache_hit));

endmodule

// File: tb/tb_l2_cache_read_multi.sv
module tb_l2_cache_read_multi;
`ifdef L2_SYNC_TIMEOUT_EN
  localparam int TO    = 7;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1023;
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_FLUSH = 3'd2;
  localparam logic [2:0] OP_LSYNC = 3'd4, OP_SSYNC = 3'd5;

  typedef struct packed {
    logic valid; logic [2:0] op; logic core; logic [1:0] strand; logic [25:0] addr;
    logic fill; logic hit; logic [1:0] hw; logic [1:0] fw; logic [17:0] tag; logic dirty;
  } sb_t;
  typedef struct packed { sb_t sb; logic succ; logic [511:0] data; } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_is_fill = 1'b0, in_cache_hit = 1'b0, wr_enable = 1'b0;
  logic [2:0] in_op = '0;
  logic [0:0] in_core = '0;
  logic [1:0] in_strand = '0, in_hit_way = '0, in_fill_way = '0;
  logic [25:0] in_address = '0;
  logic [17:0] in_old_tag = '0;
  logic [3:0] in_dirty = '0;
  logic [9:0] wr_index = '0;
  logic [511:0] wr_data = '0;

  logic a_valid, a_fill, a_hit, a_dirty, a_succ, b_valid, b_fill, b_hit, b_dirty, b_succ;
  logic [2:0] a_op, b_op;
  logic [0:0] a_core, b_core;
  logic [1:0] a_strand, a_hw, a_fw, b_strand, b_hw, b_fw;
  logic [25:0] a_addr, b_addr;
  logic [17:0] a_tag, b_tag;
  logic [511:0] a_data, b_data;

  always #5 clk = ~clk;

  l2_cache_read_multi #(.SYNC_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_core(in_core),
    .in_strand(in_strand), .in_address(in_address), .in_is_fill(in_is_fill),
    .in_cache_hit(in_cache_hit), .in_hit_way(in_hit_way), .in_fill_way(in_fill_way),
    .in_old_tag(in_old_tag), .in_dirty(in_dirty), .wr_enable(wr_enable), .wr_index(wr_index),
    .wr_data(wr_data), .out_valid(a_valid), .out_op(a_op), .out_core(a_core),
    .out_strand(a_strand), .out_address(a_addr), .out_is_fill(a_fill), .out_cache_hit(a_hit),
    .out_hit_way(a_hw), .out_fill_way(a_fw), .out_old_tag(a_tag), .out_line_is_dirty(a_dirty),
    .out_store_sync_success(a_succ), .out_cache_data(a_data));

  l2_cache_read_multi #(.READ_LATENCY(3), .SYNC_TIMEOUT(TO)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_core(in_core),
    .in_strand(in_strand), .in_address(in_address), .in_is_fill(in_is_fill),
    .in_cache_hit(in_cache_hit), .in_hit_way(in_hit_way), .in_fill_way(in_fill_way),
    .in_old_tag(in_old_tag), .in_dirty(in_dirty), .wr_enable(wr_enable), .wr_index(wr_index),
    .wr_data(wr_data), .out_valid(b_valid), .out_op(b_op), .out_core(b_core),
    .out_strand(b_strand), .out_address(b_addr), .out_is_fill(b_fill), .out_cache_hit(b_hit),
    .out_hit_way(b_hw), .out_fill_way(b_fw), .out_old_tag(b_tag), .out_line_is_dirty(b_dirty),
    .out_store_sync_success(b_succ), .out_cache_data(b_data));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: SRAM image, reservations with load time, last read line.
  logic [511:0] m_mem [1024];
  logic [511:0] m_data = '0;
  logic [3:0]   m_valid = '0;
  logic [25:0]  m_addr [4];
  int           m_time [4];
  int           cyc = 0;
  rec_t         rec_next = '0;
  rec_t         hist [4];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Prediction for the inputs currently applied, then the state they leave behind.
  task automatic model_step();
    int req, idx;
    bit rd, live, can, clr;
    logic [25:0] ev;
    req  = int'(in_strand);
    rd   = in_valid && (in_cache_hit || in_is_fill);
    idx  = (in_is_fill ? int'(in_fill_way) : int'(in_hit_way)) * 256 + int'(in_address[7:0]);
    live = m_valid[req] && (!TO_EN || (cyc - m_time[req] <= TO + 1));
    can  = (in_op == OP_SSYNC) && live && (m_addr[req] == in_address);
    if (rd) m_data = (wr_enable && int'(wr_index) == idx) ? wr_data : m_mem[idx];
    rec_next.sb = {in_valid, in_op, in_core, in_strand, in_address, in_is_fill, in_cache_hit,
                   in_hit_way, in_fill_way, in_old_tag,
                   in_dirty[(in_op == OP_FLUSH) ? in_hit_way : in_fill_way]};
    rec_next.succ = rd && can;
    rec_next.data = m_data;
    if (wr_enable) m_mem[wr_index] = wr_data;
    if (rd) begin
      clr = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd3) || (in_op == OP_SSYNC && can);
      ev  = {in_old_tag, in_address[7:0]};
      for (int j = 0; j < 4; j++) begin
        if (clr && m_addr[j] == in_address) m_valid[j] = 1'b0;
        if (in_is_fill && m_addr[j] == ev) m_valid[j] = 1'b0;
      end
      if (in_op == OP_LSYNC) begin
        m_valid[req] = 1'b1;
        m_addr[req]  = in_address;
        m_time[req]  = cyc;
      end
    end
    cyc++;
  endtask

  task automatic model_reset();
    rec_next = '0;
    m_data   = '0;
    m_valid  = '0;
    for (int j = 0; j < 4; j++) begin m_addr[j] = '0; m_time[j] = 0; end
  endtask

  // Compare process: latency-1 DUT against the prediction one cycle old, latency-3 DUT three.
  always @(posedge clk) begin
    sb_t sa, sb;
    if (!reset) begin
      for (int k = 0; k < 4; k++) hist[k] = '0;
    end else begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = rec_next;
    end
    #1;
    sa = {a_valid, a_op, a_core, a_strand, a_addr, a_fill, a_hit, a_hw, a_fw, a_tag, a_dirty};
    sb = {b_valid, b_op, b_core, b_strand, b_addr, b_fill, b_hit, b_hw, b_fw, b_tag, b_dirty};
    chk("lat1_sideband", 512'(sa), 512'(hist[1].sb));
    chk("lat1_sync_ok", 512'(a_succ), 512'(hist[1].succ));
    chk("lat1_data", a_data, hist[1].data);
    chk("lat3_sideband", 512'(sb), 512'(hist[3].sb));
    chk("lat3_sync_ok", 512'(b_succ), 512'(hist[3].succ));
    chk("lat3_data", b_data, hist[3].data);
  end

  task automatic apply(input logic v, input logic [2:0] op, input logic [1:0] st,
                       input logic [25:0] addr, input logic fill, input logic hit,
                       input logic [1:0] hw, input logic [1:0] fw, input logic [17:0] tag,
                       input logic [3:0] dirty, input logic we, input logic [9:0] widx,
                       input logic [511:0] wdat);
    in_valid = v; in_op = op; in_strand = st; in_address = addr; in_is_fill = fill;
    in_cache_hit = hit; in_hit_way = hw; in_fill_way = fw; in_old_tag = tag; in_dirty = dirty;
    wr_enable = we; wr_index = widx; wr_data = wdat;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    apply(1'b0, OP_LOAD, 2'd0, '0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 4'd0, 1'b0, '0, '0);
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] st, input logic [25:0] addr,
                     input logic [1:0] hw, input logic [3:0] dirty);
    apply(1'b1, op, st, addr, 1'b0, 1'b1, hw, 2'd0, '0, dirty, 1'b0, '0, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    logic [511:0] pa5;
    logic [511:0] p5a;
    int k;
    pa5 = {64{8'hA5}};
    p5a = {64{8'h5A}};
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", 512'(a_valid), 512'(0));
    chk("reset_data", a_data, '0);
    reset = 1'b1;

    for (int i = 0; i < 1024; i++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      apply(1'b0, OP_LOAD, 2'd0, '0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 4'd0, 1'b1, 10'(i), d);
    end

    // Load-sync then store-sync from the same strand succeeds once.
    req(OP_LSYNC, 2'd2, 26'h0001234, 2'd1, 4'd0);
    req(OP_SSYNC, 2'd2, 26'h0001234, 2'd1, 4'd0);
    chk("t1_sync_ok", 512'(a_succ), 512'(1));
    chk("t1_valid", 512'(a_valid), 512'(1));
    req(OP_SSYNC, 2'd2, 26'h0001234, 2'd1, 4'd0);
    chk("t1_second_sync", 512'(a_succ), 512'(0));

    // Another strand's store kills the reservation.
    req(OP_LSYNC, 2'd1, 26'h0000040, 2'd0, 4'd0);
    req(OP_STORE, 2'd3, 26'h0000040, 2'd0, 4'd0);
    req(OP_SSYNC, 2'd1, 26'h0000040, 2'd0, 4'd0);
    chk("t2_sync_ok", 512'(a_succ), 512'(0));

    // Write way2/set5 then read it; then a same-cycle write+read is forwarded.
    apply(1'b0, OP_LOAD, 2'd0, '0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 4'd0, 1'b1, 10'd517, pa5);
    req(OP_LOAD, 2'd0, 26'h0000105, 2'd2, 4'd0);
    chk("t3_lat1_data", a_data, pa5);
    idle();
    chk("t3_lat3_early", 512'(b_valid), 512'(0));
    idle();
    chk("t3_lat3_valid", 512'(b_valid), 512'(1));
    chk("t3_lat3_data", b_data, pa5);
    apply(1'b1, OP_LOAD, 2'd0, 26'h0000105, 1'b0, 1'b1, 2'd2, 2'd0, '0, 4'd0, 1'b1, 10'd517, p5a);
    chk("t3_bypass", a_data, p5a);

    // Fill evicting a reserved line; flush dirty select uses the hit way.
    req(OP_LSYNC, 2'd0, 26'h0001207, 2'd0, 4'd0);
    apply(1'b1, OP_LOAD, 2'd0, 26'h0003307, 1'b1, 1'b0, 2'd0, 2'd3, 18'h12, 4'b1000, 1'b0, '0, '0);
    chk("t4_fill_dirty", 512'(a_dirty), 512'(1));
    req(OP_SSYNC, 2'd0, 26'h0001207, 2'd0, 4'd0);
    chk("t4_evicted_sync", 512'(a_succ), 512'(0));
    req(OP_FLUSH, 2'd0, 26'h0000207, 2'd0, 4'b1000);
    chk("t4_flush_dirty", 512'(a_dirty), 512'(0));

    // Reset mid-stream discards in-flight requests and reservations.
    req(OP_LSYNC, 2'd0, 26'h0000055, 2'd0, 4'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    wr_enable = 1'b0;
    model_reset();
    #1;
    chk("t5_lat1_valid", 512'(a_valid), 512'(0));
    chk("t5_lat3_valid", 512'(b_valid), 512'(0));
    chk("t5_data", a_data, '0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    req(OP_SSYNC, 2'd0, 26'h0000055, 2'd0, 4'd0);
    chk("t5_sync_after_reset", 512'(a_succ), 512'(0));

    // Reservation lifetime.
    req(OP_LSYNC, 2'd0, 26'h0000077, 2'd0, 4'd0);
    repeat (4) idle();
    req(OP_SSYNC, 2'd0, 26'h0000077, 2'd0, 4'd0);
    chk("t6_sync_5", 512'(a_succ), 512'(1));
    req(OP_LSYNC, 2'd0, 26'h0000077, 2'd0, 4'd0);
    repeat (8) idle();
    req(OP_SSYNC, 2'd0, 26'h0000077, 2'd0, 4'd0);
`ifdef L2_SYNC_TIMEOUT_EN
    chk("t6_sync_9_expired", 512'(a_succ), 512'(0));
`else
    chk("t6_sync_9_persists", 512'(a_succ), 512'(1));
`endif

    // Random traffic over a small address pool so reservations collide often.
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      k = $urandom_range(0, 2);
      apply($urandom_range(0, 9) < 7, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
            {16'h0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3))}, k == 1, k == 0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 18'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom_range(0, 9) < 3,
            {2'($urandom_range(0, 3)), 8'($urandom_range(0, 3))}, d);
    end
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
